// File: rtl/addr_calc_ctrl_pkg.sv
// Shared types for the effective-address sequencer: FSM states,
// addressing-mode encodings and the ALU opcode constants it issues.
package addr_calc_ctrl_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_INDEX = 2'b00;
  localparam logic [1:0] MODE_REL   = 2'b01;
  localparam logic [1:0] MODE_ZP    = 2'b10;

  localparam logic [2:0] ALU_OR  = 3'd0;
  localparam logic [2:0] ALU_AND = 3'd1;
  localparam logic [2:0] ALU_EOR = 3'd2;
  localparam logic [2:0] ALU_ADD = 3'd3;
  localparam logic [2:0] ALU_SUB = 3'd4;

endpackage

// File: rtl/addr_calc_ctrl_if.sv
// Request/result and ALU micro-op bundle of the address sequencer.
// slave = the sequencer, master = decoder plus ALU side.
interface addr_calc_ctrl_if;
  import addr_calc_ctrl_pkg::*;

  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] offset;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] result;
  logic              page_cross;
  logic [2:0]        alu_control;
  logic [DATA_W-1:0] alu_AI;
  logic [DATA_W-1:0] alu_BI;
  logic              alu_carry_in;
  logic [DATA_W-1:0] alu_Y;
  logic              alu_carry_out;

  modport slave (
    input  start, mode, base, offset,
    input  alu_Y, alu_carry_out,
    output busy, done, result, page_cross,
    output alu_control, alu_AI, alu_BI,
    output alu_carry_in
  );

  modport master (
    output start, mode, base, offset,
    output alu_Y, alu_carry_out,
    input  busy, done, result, page_cross,
    input  alu_control, alu_AI, alu_BI,
    input  alu_carry_in
  );

endinterface

// File: rtl/addr_calc_ctrl.sv
// Two-step ADD sequencer on the shared 8-bit ALU for 16-bit addresses.
// Define ADDR_CALC_PAGE_SKIP_EN to skip HI when no page is crossed.
module addr_calc_ctrl
  import addr_calc_ctrl_pkg::*;
(
  input logic clk,
  input logic resetn,
  addr_calc_ctrl_if.slave bus
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_base;
  logic [DATA_W-1:0] r_off;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_lo;
  logic              r_c;
  logic [ADDR_W-1:0] r_result;
  logic              r_pcross;

  logic [2:0]        w_alu_ctrl;
  logic [DATA_W-1:0] w_ai;
  logic [DATA_W-1:0] w_bi;
  logic              w_cin;
  logic              w_skip;
  logic              w_is_zp;
  logic              w_is_rel;

  assign w_is_zp  = (r_mode == MODE_ZP);
  assign w_is_rel = (r_mode == MODE_REL);

  // High byte is unchanged when the low carry cancels the sign fill
`ifdef ADDR_CALC_PAGE_SKIP_EN
  assign w_skip =
    ((r_mode == MODE_INDEX) && !bus.alu_carry_out) ||
    (w_is_rel && (bus.alu_carry_out == r_off[7]));
`else
  assign w_skip = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    w_alu_ctrl = ALU_ADD;
    w_ai       = '0;
    w_bi       = '0;
    w_cin      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_LO;
      end
      S_LO: begin
        w_ai = r_base[7:0];
        w_bi = r_off;
        if (w_is_zp || w_skip)
          w_next = S_DONE;
        else
          w_next = S_HI;
      end
      S_HI: begin
        w_ai   = r_base[15:8];
        w_bi   = (w_is_rel && r_off[7])
                 ? 8'hFF : 8'h00;
        w_cin  = r_c;
        w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_off    <= '0;
      r_mode   <= MODE_INDEX;
      r_lo     <= '0;
      r_c      <= 1'b0;
      r_result <= '0;
      r_pcross <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_base <= bus.base;
            r_off  <= bus.offset;
            r_mode <= (bus.mode == 2'b11)
                      ? MODE_INDEX : bus.mode;
          end
        end
        S_LO: begin
          r_lo <= bus.alu_Y;
          r_c  <= bus.alu_carry_out;
          if (w_is_zp) begin
            r_result <= {8'h00, bus.alu_Y};
            r_pcross <= 1'b0;
          end else if (w_skip) begin
            r_result <= {r_base[15:8], bus.alu_Y};
            r_pcross <= 1'b0;
          end
        end
        S_HI: begin
          r_result <= {bus.alu_Y, r_lo};
          r_pcross <= (bus.alu_Y != r_base[15:8]);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = (r_state == S_LO) ||
                            (r_state == S_HI);
  assign bus.done         = (r_state == S_DONE);
  assign bus.result       = r_result;
  assign bus.page_cross   = r_pcross;
  assign bus.alu_control  = w_alu_ctrl;
  assign bus.alu_AI       = w_ai;
  assign bus.alu_BI       = w_bi;
  assign bus.alu_carry_in = w_cin;

endmodule

// File: tb/tb_addr_calc_ctrl.sv
// Directed-vector bench for addr_calc_ctrl with a behavioural ALU.
// Honours ADDR_CALC_PAGE_SKIP_EN for the expected latencies.
module tb_addr_calc_ctrl;
  import addr_calc_ctrl_pkg::*;

`ifdef ADDR_CALC_PAGE_SKIP_EN
  localparam int LAT_SKIP = 3;
`else
  localparam int LAT_SKIP = 4;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  addr_calc_ctrl_if bus ();

  addr_calc_ctrl u_dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  assign {bus.alu_carry_out, bus.alu_Y} =
    {1'b0, bus.alu_AI} + {1'b0, bus.alu_BI} +
    {8'd0, bus.alu_carry_in};

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"}, 16'(bus.busy), 16'h0);
    check({tag, ".done"}, 16'(bus.done), 16'h0);
    check({tag, ".res"}, bus.result, 16'h0000);
    check({tag, ".pc"}, 16'(bus.page_cross), 16'h0);
    check({tag, ".op"}, 16'(bus.alu_control),
          16'(ALU_ADD));
    check({tag, ".ai"}, 16'(bus.alu_AI), 16'h0);
    check({tag, ".bi"}, 16'(bus.alu_BI), 16'h0);
    check({tag, ".ci"}, 16'(bus.alu_carry_in), 16'h0);
  endtask

  // Cycle 1 is the cycle in which start is presented
  task automatic calc(input string tag,
                      input logic [1:0] m,
                      input logic [15:0] b,
                      input logic [7:0] o,
                      input logic [15:0] er,
                      input logic epc,
                      input int elat);
    int cyc;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mode   = m;
    bus.base   = b;
    bus.offset = o;
    cyc = 1;
    @(negedge clk);
    cyc = 2;
    bus.start  = 1'b0;
    bus.base   = ~b;
    bus.offset = ~o;
    bus.mode   = ~m;
    check({tag, ".busy"}, 16'(bus.busy), 16'h1);
    while (!bus.done && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".done"}, 16'(bus.done), 16'h1);
    check({tag, ".lat"}, 16'(cyc), 16'(elat));
    check({tag, ".res"}, bus.result, er);
    check({tag, ".pc"}, 16'(bus.page_cross), 16'(epc));
    @(negedge clk);
    check({tag, ".pulse"}, 16'(bus.done), 16'h0);
    check({tag, ".hold"}, bus.result, er);
  endtask

  initial begin
    int cyc;
    int seen;
    bus.start  = 1'b0;
    bus.mode   = 2'b00;
    bus.base   = 16'h0000;
    bus.offset = 8'h00;
    repeat (2) @(negedge clk);
    check_idle("rst");
    resetn = 1'b1;
    @(negedge clk);
    check_idle("idle");

    calc("idx",     2'b00, 16'h1234, 8'h05,
         16'h1239, 1'b0, LAT_SKIP);
    calc("idx_pc",  2'b00, 16'h12F0, 8'h20,
         16'h1310, 1'b1, 4);
    calc("rel_neg", 2'b01, 16'h1000, 8'h80,
         16'h0F80, 1'b1, 4);
    calc("rel_pos", 2'b01, 16'h1000, 8'h7F,
         16'h107F, 1'b0, LAT_SKIP);
    calc("rel_bk",  2'b01, 16'h1050, 8'hF0,
         16'h1040, 1'b0, LAT_SKIP);
    calc("zp",      2'b10, 16'h00F0, 8'h20,
         16'h0010, 1'b0, 3);
    calc("wrap",    2'b00, 16'hFFFF, 8'h01,
         16'h0000, 1'b1, 4);
    calc("rsv",     2'b11, 16'h12F0, 8'h20,
         16'h1310, 1'b1, 4);

    // start pulsed while busy must not launch a second op
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mode   = 2'b00;
    bus.base   = 16'h1234;
    bus.offset = 8'h05;
    @(negedge clk);
    bus.mode   = 2'b10;
    bus.base   = 16'h0000;
    bus.offset = 8'h77;
    cyc = 2;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 3;
    while (!bus.done && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    check("bsy.done", 16'(bus.done), 16'h1);
    check("bsy.res", bus.result, 16'h1239);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    check("bsy.extra", 16'(seen), 16'h0);

    // reset dropped while in LO aborts without a done
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mode   = 2'b00;
    bus.base   = 16'h12F0;
    bus.offset = 8'h20;
    @(negedge clk);
    bus.start = 1'b0;
    check("abort.lo", 16'(bus.busy), 16'h1);
    resetn = 1'b0;
    #1;
    check_idle("abort");
    @(negedge clk);
    resetn = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    check("abort.quiet", 16'(seen), 16'h0);
    check_idle("abort.after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
